// File: rtl/if_id_buf_pkg.sv
// if_id_buf_pkg
// Shared ISA constants (also used by fetch and decode) plus the layout of one
// fetch/decode buffer entry and a small HALT-detect helper.
package if_id_buf_pkg;

  localparam int          INSTR_W   = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  OP_HALT   = 5'b00000;

  // Width of one stored entry: instr + pc + pc_inc + err.
  localparam int ENTRY_W = 3 * INSTR_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] pc_inc;
    logic               err;
  } ibuf_entry_t;

  // The opcode lives in the top five instruction bits.
  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 5] == OP_HALT;
  endfunction

endpackage

// File: rtl/ibuf_entry.sv
// ibuf_entry
// One storage slot of the fetch/decode buffer.
// Ports:
//   clk   in   clock
//   we    in   write enable; din is captured on the rising edge
//   din   in   entry {instr, pc, pc_inc, err}
//   dout  out  stored entry (registered)
// The slot contents are not reset: the owner's count/pointers decide whether
// a slot holds anything meaningful.
module ibuf_entry
  import if_id_buf_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout
);

  logic [ENTRY_W-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      data_reg <= din;
    end
  end

  assign dout = data_reg;

endmodule

// File: rtl/if_id_buf.sv
// if_id_buf
// Small circular FIFO between fetch and decode. Fetch can keep filling while
// decode is stalled, and decode can keep draining while fetch waits on memory.
// A flush (branch/jump redirect) empties the buffer; a buffered HALT blocks
// further fetches until flush or reset.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   f_valid, f_instr, f_pc,
//   f_pc_inc, f_err                fetch side entry offer
//   f_ready                        buffer can accept (state only)
//   flush                          discard everything buffered
//   d_ready                        decode consumes the head entry
//   d_valid, d_instr, d_pc,
//   d_pc_inc, d_err, d_halt        head entry (NOP/zeros when empty)
//   halt_seen                      sticky: HALT has been enqueued
//   count                          number of entries held
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       f_valid,
  input  logic [INSTR_W-1:0]         f_instr,
  input  logic [INSTR_W-1:0]         f_pc,
  input  logic [INSTR_W-1:0]         f_pc_inc,
  input  logic                       f_err,
  output logic                       f_ready,
  input  logic                       flush,
  input  logic                       d_ready,
  output logic                       d_valid,
  output logic [INSTR_W-1:0]         d_instr,
  output logic [INSTR_W-1:0]         d_pc,
  output logic [INSTR_W-1:0]         d_pc_inc,
  output logic                       d_err,
  output logic                       d_halt,
  output logic                       halt_seen,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             halt_seen_reg;

  logic             enq;
  logic             deq;
  ibuf_entry_t      wr_entry;
  ibuf_entry_t      head;
  logic [ENTRY_W-1:0] slot_q [DEPTH];

  // f_ready is purely a function of state; accepting into a full buffer in
  // the same cycle decode drains it is deliberately not supported.
  assign f_ready = (count_reg < CNT_W'(DEPTH)) && !halt_seen_reg;
  assign d_valid = (count_reg != '0);

  assign enq = f_valid && f_ready && !flush;
  assign deq = d_valid && d_ready && !flush;

  assign wr_entry = '{instr: f_instr, pc: f_pc, pc_inc: f_pc_inc, err: f_err};

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      ibuf_entry u_entry (
        .clk  (clk),
        .we   (enq && (wr_ptr_reg == PTR_W'(gi))),
        .din  (wr_entry),
        .dout (slot_q[gi])
      );
    end
  endgenerate

  assign head = ibuf_entry_t'(slot_q[rd_ptr_reg]);

  // Empty buffer presents a NOP with zeroed side-band so decode never sees
  // stale slot contents.
  assign d_instr  = d_valid ? head.instr  : NOP_INSTR;
  assign d_pc     = d_valid ? head.pc     : '0;
  assign d_pc_inc = d_valid ? head.pc_inc : '0;
  assign d_err    = d_valid ? head.err    : 1'b0;
  assign d_halt   = d_valid && is_halt(head.instr);

  assign halt_seen = halt_seen_reg;
  assign count     = count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      halt_seen_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      halt_seen_reg <= 1'b0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (enq) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (enq && !deq) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (deq && !enq) begin
        count_reg <= count_reg - CNT_W'(1);
      end
      if (enq && is_halt(f_instr)) begin
        halt_seen_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_id_buf.sv
// tb_if_id_buf
// Directed scenarios followed by randomized traffic. A queue-based reference
// model predicts the buffer's visible state after every clock edge, and every
// output is compared against it one time unit after the edge.
module tb_if_id_buf;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid;
  logic [15:0] f_instr;
  logic [15:0] f_pc;
  logic [15:0] f_pc_inc;
  logic        f_err;
  logic        f_ready;
  logic        flush;
  logic        d_ready;
  logic        d_valid;
  logic [15:0] d_instr;
  logic [15:0] d_pc;
  logic [15:0] d_pc_inc;
  logic        d_err;
  logic        d_halt;
  logic        halt_seen;
  logic [1:0]  count;

  if_id_buf #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .f_valid   (f_valid),
    .f_instr   (f_instr),
    .f_pc      (f_pc),
    .f_pc_inc  (f_pc_inc),
    .f_err     (f_err),
    .f_ready   (f_ready),
    .flush     (flush),
    .d_ready   (d_ready),
    .d_valid   (d_valid),
    .d_instr   (d_instr),
    .d_pc      (d_pc),
    .d_pc_inc  (d_pc_inc),
    .d_err     (d_err),
    .d_halt    (d_halt),
    .halt_seen (halt_seen),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic        err;
  } ent_t;

  ent_t q[$];
  bit   m_halt;
  bit   last_enq;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    int   n;
    bit   v;
    ent_t h;
    n = q.size();
    v = (n != 0);
    if (v) h = q[0];
    else   h = '{instr: 16'h0800, pc: 16'h0, pc_inc: 16'h0, err: 1'b0};
    check("count",     32'(count),     32'(n));
    check("f_ready",   32'(f_ready),   32'((n < DEPTH) && !m_halt));
    check("d_valid",   32'(d_valid),   32'(v));
    check("d_instr",   32'(d_instr),   32'(h.instr));
    check("d_pc",      32'(d_pc),      32'(h.pc));
    check("d_pc_inc",  32'(d_pc_inc),  32'(h.pc_inc));
    check("d_err",     32'(d_err),     32'(h.err));
    check("d_halt",    32'(d_halt),    32'(v && (h.instr[15:11] == 5'b00000)));
    check("halt_seen", 32'(halt_seen), 32'(m_halt));
  endtask

  // One clock edge: update the model from the inputs held across the edge,
  // then compare all outputs.
  task automatic cycle();
    bit   m_enq;
    bit   m_deq;
    ent_t e;
    @(posedge clk);
    m_enq = 1'b0;
    m_deq = 1'b0;
    if (rst || flush) begin
      q.delete();
      m_halt = 1'b0;
    end else begin
      m_deq = d_ready && (q.size() != 0);
      m_enq = f_valid && (q.size() < DEPTH) && !m_halt;
      if (m_deq) begin
        e = q.pop_front();
        $display("deq instr=%h pc=%h pc_inc=%h err=%0b", e.instr, e.pc, e.pc_inc, e.err);
      end
      if (m_enq) begin
        q.push_back('{instr: f_instr, pc: f_pc, pc_inc: f_pc_inc, err: f_err});
        if (f_instr[15:11] == 5'b00000) m_halt = 1'b1;
      end
    end
    last_enq = m_enq;
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc,
                       input logic err, input logic fl, input logic dr);
    f_valid  = v;
    f_instr  = instr;
    f_pc     = pc;
    f_pc_inc = pc + 16'd2;
    f_err    = err;
    flush    = fl;
    d_ready  = dr;
  endtask

  // Hold an offer until the model says it was taken (bounded).
  task automatic offer(input logic [15:0] instr, input logic [15:0] pc,
                       input logic err, input logic dr);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, instr, pc, err, 1'b0, dr);
      cycle();
      if (last_enq) break;
    end
    f_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] ri;
    rst = 1'b1;
    m_halt = 1'b0;
    drive(1'b1, 16'hBEEF, 16'h0100, 1'b0, 1'b0, 1'b1);

    // Reset with f_valid high.
    cycle();
    cycle();
    rst = 1'b0;

    // Streaming.
    drive(1'b1, 16'hA101, 16'h0000, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b1, 16'hA202, 16'h0002, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b0, 16'h0,    16'h0,    1'b0, 1'b0, 1'b1); cycle();
    cycle();

    // Backpressure and full.
    drive(1'b1, 16'hA303, 16'h0004, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'hA404, 16'h0006, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'hA505, 16'h0008, 1'b0, 1'b0, 1'b0); cycle();
    cycle();
    offer(16'hA505, 16'h0008, 1'b0, 1'b1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle();

    // Flush with f_valid and d_ready in the same cycle.
    offer(16'hB111, 16'h0010, 1'b0, 1'b0);
    offer(16'hB222, 16'h0012, 1'b0, 1'b0);
    drive(1'b1, 16'hB333, 16'h0014, 1'b0, 1'b1, 1'b1); cycle();
    drive(1'b1, 16'h4000, 16'h0040, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1); cycle();
    cycle();

    // Halt, then flush clears it.
    offer(16'h1234, 16'h0050, 1'b0, 1'b0);
    offer(16'h0000, 16'h0052, 1'b0, 1'b0);
    drive(1'b1, 16'hC000, 16'h0054, 1'b0, 1'b0, 1'b1);
    repeat (4) cycle();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0); cycle();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0); cycle();

    // Error and pointer wrap: 7 streamed entries, error on the 5th.
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 16'hD000 + 16'(k), 16'h0100 + 16'(2 * k), (k == 4), 1'b0, 1'b1);
      cycle();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) cycle();

    // Randomized traffic.
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      ri  = 16'($urandom);
      if ($urandom_range(0, 9) == 0) ri[15:11] = 5'b00000;
      drive($urandom_range(0, 3) != 0, ri, 16'($urandom) & 16'hFFFE,
            $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 2) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
